// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder with wait states over a 64-bit word array.
// Optional DMEM_FAULT_CHECK_EN enables misalignment and range faults; otherwise
// offsets are forced to size alignment and the word index wraps.
module dmem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_v,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_v,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_fault
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        l_we;
    logic [1:0]  l_size;
    logic [63:0] l_addr, l_wdata;
    logic [63:0] mem [DEPTH_WORDS];

    logic          accept, do_access, fault, a_we;
    logic [1:0]    a_size;
    logic [63:0]   a_addr, a_wdata;
    logic [2:0]    amask, off;
    logic [5:0]    sh;
    logic [IW-1:0] idx;
    logic [63:0]   dmask, wmask, old_word, new_word, rd_word;

    // With zero wait states the access happens on the accept edge, so it uses the live request.
    always_comb begin
        accept    = state == S_IDLE && req_ready && req_v;
        do_access = (WAIT_STATES == 0) ? accept : (state == S_WAIT && cnt == 4'd0);
        a_we      = (state == S_IDLE) ? req_we : l_we;
        a_size    = (state == S_IDLE) ? req_size : l_size;
        a_addr    = (state == S_IDLE) ? req_addr : l_addr;
        a_wdata   = (state == S_IDLE) ? req_wdata : l_wdata;
        amask     = 3'((4'd1 << a_size) - 4'd1);
`ifdef DMEM_FAULT_CHECK_EN
        off   = a_addr[2:0];
        fault = (|(off & amask)) || (a_addr[63:3] >= 61'(DEPTH_WORDS));
        idx   = IW'(a_addr[63:3]);
`else
        off   = a_addr[2:0] & ~amask;
        fault = 1'b0;
        idx   = IW'(a_addr[63:3] % 61'(DEPTH_WORDS));
`endif
        sh       = {off, 3'b000};
        dmask    = (a_size == 2'd3) ? '1 : (64'd1 << (7'd8 << a_size)) - 64'd1;
        wmask    = dmask << sh;
        old_word = mem[idx];
        new_word = (old_word & ~wmask) | ((a_wdata & dmask) << sh);
        rd_word  = (old_word >> sh) & dmask;
    end

    // Array write on the access edge; faulting stores leave memory untouched.
    always_ff @(posedge clk) begin
        if (do_access && a_we && !fault)
            mem[idx] <= new_word;
    end

    // Request/wait/response sequencing with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            resp_v     <= 1'b0;
            resp_rdata <= 64'd0;
            resp_fault <= 1'b0;
            l_we       <= 1'b0;
            l_size     <= 2'd0;
            l_addr     <= 64'd0;
            l_wdata    <= 64'd0;
        end else begin
            if (accept) begin
                l_we      <= req_we;
                l_size    <= req_size;
                l_addr    <= req_addr;
                l_wdata   <= req_wdata;
                req_ready <= 1'b0;
                state     <= S_WAIT;
                cnt       <= 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
            end else if (state == S_IDLE) begin
                req_ready <= 1'b1;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else if (state == S_RESP && resp_ready) begin
                state      <= S_IDLE;
                resp_v     <= 1'b0;
                resp_rdata <= 64'd0;
                resp_fault <= 1'b0;
                req_ready  <= 1'b1;
            end
            if (do_access) begin
                state      <= S_RESP;
                resp_v     <= 1'b1;
                resp_rdata <= (a_we || fault) ? 64'd0 : rd_word;
                resp_fault <= fault;
            end
        end
    end
endmodule
